// File: rtl/fpnew_slice_out_arbiter.sv
// Output collection stage for the format slices of one opgroup: a round-robin
// arbiter feeding a single registered output stage with a valid/ready handshake.
module fpnew_slice_out_arbiter #(
    parameter int unsigned NumSlices = 4,
    parameter int unsigned Width     = 32,
    parameter int unsigned IDX_W     = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumSlices-1:0]       slice_valid_i,
    output logic [NumSlices-1:0]       slice_ready_o,
    input  logic [NumSlices*Width-1:0] slice_result_i,
    input  logic [NumSlices*5-1:0]     slice_status_i,
    input  logic [NumSlices-1:0]       slice_ext_bit_i,
    input  logic [NumSlices-1:0]       slice_tag_i,
    input  logic                       flush_i,
    output logic [Width-1:0]           result_o,
    output logic [4:0]                 status_o,
    output logic                       extension_bit_o,
    output logic                       tag_o,
    output logic [IDX_W-1:0]           slice_idx_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o
);

    logic                 valid_q;
    logic [IDX_W-1:0]     rr_q;
    logic [Width-1:0]     result_q;
    logic [4:0]           status_q;
    logic                 ext_q;
    logic                 tag_q;
    logic [IDX_W-1:0]     idx_q;

    logic [NumSlices-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_vld;
    logic [IDX_W-1:0]     cand_idx;
    logic                 load_en;
    logic                 load_ok;
    logic                 transfer;

    // Slice index reached by stepping 'off' positions past 'base', wrapping at NumSlices.
    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        return IDX_W'((base + off) % NumSlices);
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand_idx  = '0;
        for (int k = 0; k < NumSlices; k++) begin
            cand_idx = wrap_idx(int'(rr_q), k);
            if (!grant_vld && slice_valid_i[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant[grant_idx] = grant_vld;
    end

    // Reset and flush both block the slice handshake so no beat can be lost.
    assign load_en       = ~valid_q | out_ready_i;
    assign load_ok       = load_en & ~flush_i & ~rst_i;
    assign transfer      = load_ok & grant_vld;
    assign slice_ready_o = grant & {NumSlices{load_ok}};

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            rr_q     <= '0;
            result_q <= '0;
            status_q <= '0;
            ext_q    <= 1'b0;
            tag_q    <= 1'b0;
            idx_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (transfer) begin
            valid_q  <= 1'b1;
            rr_q     <= wrap_idx(int'(grant_idx), 1);
            result_q <= slice_result_i[int'(grant_idx)*Width +: Width];
            status_q <= slice_status_i[int'(grant_idx)*5 +: 5];
            ext_q    <= slice_ext_bit_i[grant_idx];
            tag_q    <= slice_tag_i[grant_idx];
            idx_q    <= grant_idx;
        end else if (valid_q && out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o     = valid_q;
    assign result_o        = result_q;
    assign status_o        = status_q;
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_q;
    assign slice_idx_o     = idx_q;
    assign busy_o          = valid_q | (|slice_valid_i);

endmodule

// File: doc/fpnew_slice_out_arbiter.md
# fpnew_slice_out_arbiter

Downstream collection stage for the per-format operation slices of one opgroup. Round-robin arbitrates among `NumSlices` slice outputs, each carrying result, status, extension bit and tag. Registers the winner into a single output stage with a valid/ready handshake toward the FPU output mux. Returns the per-slice ready and reports which slice produced the registered result.

## Interface
- `NumSlices`, default 4: number of format slices feeding the arbiter, at least 1.
- `Width`, default 32: result width, identical to the slice `Width`.
- `IDX_W`, derived: max(1, $clog2(NumSlices)). Do not override.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `slice_valid_i`  in  NumSlices  per-slice output valid.
- `slice_ready_o`  out  NumSlices  per-slice output ready.
- `slice_result_i`  in  NumSlices×Width  per-slice result.
- `slice_status_i`  in  NumSlices×5  per-slice `fpnew_pkg::status_t` as {NV,DZ,OF,UF,NX}.
- `slice_ext_bit_i`  in  NumSlices  per-slice extension bit.
- `slice_tag_i`  in  NumSlices  per-slice tag.
- `flush_i`  in  1  discard the registered result.
- `result_o`  out  Width  registered result.
- `status_o`  out  5  registered status.
- `extension_bit_o`  out  1  registered extension bit.
- `tag_o`  out  1  registered tag.
- `slice_idx_o`  out  IDX_W  index of the slice that produced the registered result.
- `out_valid_o`  out  1  output valid.
- `out_ready_i`  in  1  output ready.
- `busy_o`  out  1  data in flight.

## Operation
State:
- Output register: `valid_q` plus data fields.
- Round-robin pointer `rr_q` (IDX_W bits, range 0..NumSlices-1).

Arbitration (combinational):
- Grant goes to the first `i` with `slice_valid_i[i]=1`, searching `rr_q, rr_q+1, …` modulo NumSlices.
- At most one grant bit is set; none is set when no slice is valid.

Load enable:
- `load_en = ~valid_q | out_ready_i`.
- `slice_ready_o[i] = load_en & grant[i]`. Non-granted slices always see ready=0.

Transfer:
- A transfer occurs when `load_en` is high and some grant bit is set.
- On a transfer, the output register captures the granted slice's result, status, ext bit and tag, plus its index.
- On a transfer, `valid_q <= 1` and `rr_q <= (grant_idx+1) mod NumSlices`. Wrap-around: a grant at NumSlices-1 sets `rr_q` to 0.
- Drain without refill (`valid_q & out_ready_i`, no grant): `valid_q <= 0`; data fields hold their last value.
- Drain and refill in the same cycle are allowed, giving full throughput of one result per cycle.
- If no transfer occurs, `rr_q` holds.

Backpressure:
- While `valid_q & ~out_ready_i`, all outputs are stable.
- All `slice_ready_o` are 0 during this condition; pending slices keep their valid asserted.

Flush:
- `flush_i=1`: `valid_q <= 0`. Any load in that cycle is suppressed: `slice_ready_o` is forced to 0 and no transfer occurs.
- `rr_q` holds during flush.

Busy:
- `busy_o = valid_q | (|slice_valid_i)`.

NumSlices=1:
- `rr_q` and `slice_idx_o` are constant 0.
- The block degenerates to a single pipeline register.

## Timing
- Reset (rst_i=1 at an edge): `out_valid_o`, `result_o`, `status_o`, `extension_bit_o`, `tag_o`, `slice_idx_o` and `rr_q` all 0.
  - During reset, `slice_ready_o` is forced to 0.
  - `busy_o` follows its formula.
  - Reset mid-transfer drops the registered result. No slice handshake completes in the reset cycle.
- Latency: one cycle. A slice handshake at edge N produces `out_valid_o=1` after edge N.
- Combinational paths:
  - `out_ready_i` → `slice_ready_o`.
  - `slice_valid_i` → `slice_ready_o` and `busy_o`.
  - No combinational path from `slice_*_i` data to any output.
- Priority when several conditions coincide: reset > flush > transfer.
- Fairness: with all slices continuously valid and `out_ready_i=1`, grants cycle 0,1,…,NumSlices-1,0. No slice waits more than NumSlices-1 transfers.

## Test plan
- Single slice: reset, then slice 2 valid with result 0x3F800000, status 0x01, tag 1. Required: slice_ready_o=0b0100 in that cycle; next cycle out_valid_o=1, result_o=0x3F800000, status_o=0x01, tag_o=1, slice_idx_o=2.
- Fairness and wrap: all 4 slices valid, out_ready_i=1, over 8 cycles. Required: slice_idx_o sequence 0,1,2,3,0,1,2,3 with one result per cycle.
- Backpressure: out_valid_o=1 and out_ready_i=0 for 3 cycles while slices 1 and 3 are valid. Required: outputs stable and slice_ready_o=0. On release, slice 1 is granted first if rr_q≤1.
- Simultaneous drain and refill: out_valid_o=1, out_ready_i=1, slice 0 valid. Required: out_valid_o stays 1 and result_o updates to slice 0's data on the next edge.
- Flush: flush_i=1 while out_valid_o=1 and slice 1 valid. Required: next cycle out_valid_o=0, slice_ready_o was 0 in the flush cycle, and rr_q is unchanged.
- Reset mid-operation: rst_i=1 while out_valid_o=1 with pointer at 3. Required: after the edge, all outputs are 0 and the next grant, with all slices valid, is slice 0.
